// File: rtl/pipelined_arith_unit_if.sv
// Operand/result handshake bundle for pipelined_arith_unit.
// The master side supplies operands and consumes results. The slave side is the arithmetic unit.
interface pipelined_arith_unit_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s0;
    logic             s1;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, s0, s1, cin, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, s0, s1, cin, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_arith_unit.sv
// Pipelined segmented ripple adder: F = A + f(s1,s0,B) + cin, one SEG-bit segment per stage.
// It uses a global stall under backpressure, and the flags are registered together with the result.
module pipelined_arith_unit #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_arith_unit_if.slave io
);
    localparam int STAGES = (SEG > 0 && WIDTH >= SEG) ? WIDTH / SEG : 1;
    localparam int L      = STAGES - 1;

    generate
        if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_bad_params
            $error("pipelined_arith_unit: WIDTH must be a non-zero multiple of SEG");
        end
    endgenerate

    logic                               w_stall;
    logic                               w_accept;
    logic [WIDTH-1:0]                   w_y;
    logic                               w_msb_cin;
    logic [STAGES-1:0]                  r_vld;
    logic [STAGES-1:0]                  r_c;
    logic [STAGES-1:0][WIDTH-1:0]       r_a;
    logic [STAGES-1:0][WIDTH-1:0]       r_y;
    logic [STAGES-1:0][WIDTH-1:0]       r_s;
    logic [STAGES-1:0][WIDTH-1:0]       w_res;
    logic [STAGES-1:0][SEG:0]           w_sum;
    logic                               r_out_vld;
    logic [WIDTH-1:0]                   r_out_s;
    logic                               r_cout;
    logic                               r_ovf;
    logic                               r_zero;

    assign w_stall  = r_out_vld & ~io.out_ready;
    assign w_accept = io.in_valid & ~w_stall;

    always_comb begin
        case ({io.s1, io.s0})
            2'b00:   w_y = io.b;
            2'b01:   w_y = ~io.b;
            2'b10:   w_y = '0;
            default: w_y = '1;
        endcase
    end

    // Each stage resolves its own segment from the carry registered by the stage before it.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_sum[k] = {1'b0, r_a[k][k*SEG +: SEG]} + {1'b0, r_y[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, r_c[k]};
            w_res[k] = r_s[k];
            w_res[k][k*SEG +: SEG] = w_sum[k][SEG-1:0];
        end
    end

    // Carry into the MSB can be recovered from the MSB sum bit and its two addend bits.
    assign w_msb_cin = r_a[L][WIDTH-1] ^ r_y[L][WIDTH-1] ^ w_res[L][WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld     <= '0;
            r_c       <= '0;
            r_a       <= '0;
            r_y       <= '0;
            r_s       <= '0;
            r_out_vld <= 1'b0;
            r_out_s   <= '0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
            r_zero    <= 1'b0;
        end else if (!w_stall) begin
            r_vld[0] <= w_accept;
            if (w_accept) begin
                r_a[0] <= io.a;
                r_y[0] <= w_y;
                r_s[0] <= '0;
                r_c[0] <= io.cin;
            end
            for (int k = 1; k < STAGES; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_a[k]   <= r_a[k-1];
                r_y[k]   <= r_y[k-1];
                r_s[k]   <= w_res[k-1];
                r_c[k]   <= w_sum[k-1][SEG];
            end
            r_out_vld <= r_vld[L];
            if (r_vld[L]) begin
                r_out_s <= w_res[L];
                r_cout  <= w_sum[L][SEG];
                r_ovf   <= w_msb_cin ^ w_sum[L][SEG];
                r_zero  <= (w_res[L] == '0);
            end
        end
    end

    assign io.in_ready  = ~w_stall;
    assign io.out_valid = r_out_vld;
    assign io.s         = r_out_s;
    assign io.cout      = r_cout;
    assign io.ovf       = r_ovf;
    assign io.zero      = r_zero;
endmodule
